frame_host: RTL and testbench

- Host-side counterpart of the MCU link framing: the far end of the framed serial protocol (len, seq, payload, crc16, 0x7e).
- Builds outgoing command frames from a payload ring plus a length FIFO, and drives a byte-level UART transmit interface.
- Decodes response frames from the UART receive interface, validates them, and treats them as acknowledgements.
- Used as an FPGA-resident host for a downstream MCU and as the loopback peer in link testbenches.

---
 rtl/framing_pkg.sv | 15 +
 rtl/crc16_serial.sv | 46 ++++
 rtl/frame_host.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_frame_host.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framing_pkg.sv
// Shared constants and state encodings for the framed link (len, seq, payload, crc16, 0x7e).
package framing_pkg;
   localparam logic [7:0] SYNC_CHAR = 8'h7E;
   localparam int         MIN_LEN   = 5;
   localparam int         MAX_LEN   = 64;
   localparam logic [3:0] SEQ_HI    = 4'h1;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_SEQ, S_DATA, S_CRC1, S_CRC2, S_EOF, S_WAIT_ACK
   } send_state_e;

   typedef enum logic [2:0] {
      R_SOF, R_SEQ, R_DATA, R_CRC1, R_CRC2, R_EOF, R_ERROR
   } recv_state_e;
endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC16-CCITT (reflected, poly 0x8408): a loaded byte is folded in over 8 cycles.
module crc16_serial (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        load,
   input  logic [7:0]  data_in,
   output logic [15:0] crc,
   output logic        busy
);
   logic [15:0] crc_q, crc_d;
   logic [7:0]  sh_q, sh_d;
   logic [3:0]  cnt_q, cnt_d;

   always_comb begin
      crc_d = crc_q;
      sh_d  = sh_q;
      cnt_d = cnt_q;
      if (cnt_q != 4'd0) begin
         crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ sh_q[0]) ? 16'h8408 : 16'h0000);
         sh_d  = {1'b0, sh_q[7:1]};
         cnt_d = cnt_q - 4'd1;
      end
      // init and load may coincide: the first byte of a frame starts from 0xFFFF
      if (init) crc_d = 16'hFFFF;
      if (load) begin
         sh_d  = data_in;
         cnt_d = 4'd8;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         crc_q <= 16'hFFFF;
         sh_q  <= 8'h00;
         cnt_q <= 4'd0;
      end else begin
         crc_q <= crc_d;
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
      end
   end

   assign crc  = crc_q;
   assign busy = (cnt_q != 4'd0);
endmodule

// File: rtl/frame_host.sv
// Host end of the framed serial link: sends queued command frames, decodes responses as acks.
// Optional FRAME_HOST_RETRANSMIT_EN resends an unacked frame up to 3 times before flagging error.
module frame_host
   import framing_pkg::*;
#(
   parameter int RING_BITS     = 8,
   parameter int LEN_FIFO_BITS = 2,
   parameter int ACK_TIMEOUT   = 480000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cmd_data,
   input  logic       cmd_wr_en,
   output logic       cmd_full,
   input  logic [5:0] cmd_len,
   input  logic       cmd_len_wr_en,
   output logic       cmd_len_full,
   output logic [7:0] tx_data,
   output logic       tx_en,
   input  logic       tx_busy,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_ready,
   input  logic       rsp_rd_en,
   output logic [3:0] ack_seq,
   output logic       error,
   input  logic       clr
);
   localparam int                 RD      = 1 << RING_BITS;
   localparam int                 LD      = 1 << LEN_FIFO_BITS;
   localparam int                 TO_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0]    TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [RING_BITS-1:0]   RONE = 1;
   localparam logic [LEN_FIFO_BITS:0] LONE = 1;

   // ---------------- command ring and length FIFO ----------------
   logic [7:0]           cmd_mem [RD];
   logic [5:0]           len_mem [LD];
   logic [RING_BITS-1:0] cmd_wptr_q, cmd_wptr_d, cmd_rptr_q, rd_ptr_q;
   logic [LEN_FIFO_BITS:0] len_wptr_q, len_wptr_d, len_rptr_q;
   logic cmd_we, len_we, len_empty;

   assign cmd_full     = ((cmd_wptr_q + RONE) == cmd_rptr_q);
   assign len_empty    = (len_wptr_q == len_rptr_q);
   assign cmd_len_full = (len_wptr_q[LEN_FIFO_BITS] != len_rptr_q[LEN_FIFO_BITS]) &&
                         (len_wptr_q[LEN_FIFO_BITS-1:0] == len_rptr_q[LEN_FIFO_BITS-1:0]);
   assign cmd_we       = cmd_wr_en & ~cmd_full;
   assign len_we       = cmd_len_wr_en & ~cmd_len_full;

   always_comb begin
      cmd_wptr_d = cmd_wptr_q + (cmd_we ? RONE : '0);
      len_wptr_d = len_wptr_q + (len_we ? LONE : '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_wptr_q <= '0;
         len_wptr_q <= '0;
      end else begin
         cmd_wptr_q <= cmd_wptr_d;
         len_wptr_q <= len_wptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && cmd_we) cmd_mem[cmd_wptr_q] <= cmd_data;
      if (rst_n && len_we) len_mem[len_wptr_q[LEN_FIFO_BITS-1:0]] <= cmd_len;
   end

   // ---------------- receive-side signals needed by the sender ----------------
   recv_state_e rx_state_q;
   logic [7:0]  rx_seq_q, rx_c1_q, rx_c2_q;
   logic [15:0] rx_crc;
   logic        rx_crc_busy, rx_commit;

   // ---------------- send FSM ----------------
   send_state_e send_state_q;
   logic [3:0]      tx_seq_q, ack_seq_q;
   logic [5:0]      flen_q, rem_q;
   logic [TO_W-1:0] to_cnt_q;
   logic            halted_q, tx_en_q;
   logic [7:0]      tx_data_q, tx_byte;
   logic [15:0]     tx_crc;
   logic            tx_crc_busy, tx_crc_init, tx_crc_load;
   logic            tx_sending, tx_issue, pop, timeout_hit, ack_hit, tx_fatal;
`ifdef FRAME_HOST_RETRANSMIT_EN
   logic [1:0]      retry_q;
   logic            retry_left;
   assign retry_left = (retry_q != 2'd3);
`endif

   always_comb begin
      tx_sending  = (send_state_q != S_IDLE) && (send_state_q != S_WAIT_ACK);
      tx_issue    = tx_sending & ~tx_busy & ~tx_en_q & ~tx_crc_busy & ~clr;
      pop         = (send_state_q == S_IDLE) & ~len_empty & ~clr;
      ack_hit     = rx_commit & (send_state_q == S_WAIT_ACK) & ~halted_q &
                    (rx_seq_q[3:0] == (tx_seq_q + 4'd1));
      timeout_hit = (send_state_q == S_WAIT_ACK) & ~halted_q & (to_cnt_q == TO_LAST) & ~ack_hit;
`ifdef FRAME_HOST_RETRANSMIT_EN
      tx_fatal    = timeout_hit & ~retry_left & ~clr;
      tx_crc_init = pop | (timeout_hit & retry_left & ~clr);
`else
      tx_fatal    = timeout_hit & ~clr;
      tx_crc_init = pop;
`endif
      tx_crc_load = tx_issue & ((send_state_q == S_LEN) || (send_state_q == S_SEQ) ||
                                (send_state_q == S_DATA));
      tx_byte = 8'h00;
      case (send_state_q)
         S_LEN:   tx_byte = {2'b00, flen_q} + 8'(MIN_LEN);
         S_SEQ:   tx_byte = {SEQ_HI, tx_seq_q};
         S_DATA:  tx_byte = cmd_mem[rd_ptr_q];
         S_CRC1:  tx_byte = tx_crc[15:8];
         S_CRC2:  tx_byte = tx_crc[7:0];
         S_EOF:   tx_byte = SYNC_CHAR;
         default: tx_byte = 8'h00;
      endcase
   end

   crc16_serial u_tx_crc (
      .clk(clk), .rst_n(rst_n), .init(tx_crc_init), .load(tx_crc_load),
      .data_in(tx_byte), .crc(tx_crc), .busy(tx_crc_busy)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         send_state_q <= S_IDLE;
         tx_seq_q     <= 4'd0;
         ack_seq_q    <= 4'd0;
         flen_q       <= 6'd0;
         rem_q        <= 6'd0;
         to_cnt_q     <= '0;
         halted_q     <= 1'b0;
         tx_en_q      <= 1'b0;
         tx_data_q    <= 8'h00;
         cmd_rptr_q   <= '0;
         rd_ptr_q     <= '0;
         len_rptr_q   <= '0;
`ifdef FRAME_HOST_RETRANSMIT_EN
         retry_q      <= 2'd0;
`endif
      end else begin
         tx_en_q <= 1'b0;
         if (tx_issue) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= tx_byte;
         end
         if (clr) begin
            // the frame in flight is dropped and its ring space given back
            send_state_q <= S_IDLE;
            halted_q     <= 1'b0;
            if (send_state_q != S_IDLE) cmd_rptr_q <= cmd_rptr_q + RING_BITS'(flen_q);
         end else begin
            case (send_state_q)
               S_IDLE: if (pop) begin
                  flen_q       <= len_mem[len_rptr_q[LEN_FIFO_BITS-1:0]];
                  rem_q        <= len_mem[len_rptr_q[LEN_FIFO_BITS-1:0]];
                  len_rptr_q   <= len_rptr_q + LONE;
                  rd_ptr_q     <= cmd_rptr_q;
                  halted_q     <= 1'b0;
                  send_state_q <= S_LEN;
`ifdef FRAME_HOST_RETRANSMIT_EN
                  retry_q      <= 2'd0;
`endif
               end
               S_LEN: if (tx_issue) send_state_q <= S_SEQ;
               S_SEQ: if (tx_issue) send_state_q <= (flen_q == 6'd0) ? S_CRC1 : S_DATA;
               S_DATA: if (tx_issue) begin
                  rd_ptr_q <= rd_ptr_q + RONE;
                  rem_q    <= rem_q - 6'd1;
                  if (rem_q == 6'd1) send_state_q <= S_CRC1;
               end
               S_CRC1: if (tx_issue) send_state_q <= S_CRC2;
               S_CRC2: if (tx_issue) send_state_q <= S_EOF;
               S_EOF: if (tx_issue) begin
                  to_cnt_q     <= '0;
                  send_state_q <= S_WAIT_ACK;
               end
               S_WAIT_ACK: begin
                  if (ack_hit) begin
                     ack_seq_q    <= rx_seq_q[3:0];
                     tx_seq_q     <= tx_seq_q + 4'd1;
                     cmd_rptr_q   <= cmd_rptr_q + RING_BITS'(flen_q);
                     send_state_q <= S_IDLE;
                  end else if (timeout_hit) begin
`ifdef FRAME_HOST_RETRANSMIT_EN
                     if (retry_left) begin
                        retry_q      <= retry_q + 2'd1;
                        rd_ptr_q     <= cmd_rptr_q;
                        rem_q        <= flen_q;
                        send_state_q <= S_LEN;
                     end else begin
                        halted_q <= 1'b1;
                     end
`else
                     halted_q <= 1'b1;
`endif
                  end else if (!halted_q) begin
                     to_cnt_q <= to_cnt_q + TO_W'(1);
                  end
               end
               default: send_state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign tx_en   = tx_en_q;
   assign tx_data = tx_data_q;
   assign ack_seq = ack_seq_q;

   // ---------------- receive FSM and response ring ----------------
   logic [7:0]           rsp_mem [RD];
   logic [5:0]           rx_len_q, rx_rem_q;
   logic [RING_BITS-1:0] tmp_wptr_q, rsp_wptr_q, rsp_rptr_q, rsp_rptr_d;
   logic rsp_ready_q, rsp_ready_d, rsp_full_tmp, len_bad, crc_ok, rx_to_err;
   logic rx_crc_init, rx_crc_load, rsp_we, is_sync;

   always_comb begin
      is_sync      = (rx_data == SYNC_CHAR);
      rsp_full_tmp = ((tmp_wptr_q + RONE) == rsp_rptr_q);
      len_bad      = (rx_data < 8'(MIN_LEN)) || (rx_data >= 8'(MAX_LEN));
      crc_ok       = (rx_crc == {rx_c1_q, rx_c2_q});
      rx_commit    = rx_ready & ~clr & (rx_state_q == R_EOF) & is_sync & crc_ok &
                     (rx_seq_q[7:4] == SEQ_HI);
      rx_to_err    = rx_ready & ~clr &
                     (((rx_state_q == R_SOF) & ~is_sync & len_bad) |
                      ((rx_state_q == R_DATA) & rsp_full_tmp) |
                      ((rx_state_q == R_EOF) & ~rx_commit));
      rx_crc_init  = rx_ready & (rx_state_q == R_SOF) & ~is_sync & ~len_bad;
      rx_crc_load  = rx_crc_init | (rx_ready & (rx_state_q == R_SEQ)) |
                     (rx_ready & (rx_state_q == R_DATA) & ~rsp_full_tmp);
      rsp_we       = rx_ready & ~clr & (rx_state_q == R_DATA) & ~rsp_full_tmp;
   end

   crc16_serial u_rx_crc (
      .clk(clk), .rst_n(rst_n), .init(rx_crc_init), .load(rx_crc_load),
      .data_in(rx_data), .crc(rx_crc), .busy(rx_crc_busy)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state_q <= R_SOF;
         rx_len_q   <= 6'd0;
         rx_rem_q   <= 6'd0;
         rx_seq_q   <= 8'h00;
         rx_c1_q    <= 8'h00;
         rx_c2_q    <= 8'h00;
         tmp_wptr_q <= '0;
         rsp_wptr_q <= '0;
      end else if (clr) begin
         rx_state_q <= R_SOF;
         tmp_wptr_q <= rsp_wptr_q;
      end else if (rx_ready) begin
         case (rx_state_q)
            R_SOF: if (!is_sync) begin
               if (len_bad) rx_state_q <= R_ERROR;
               else begin
                  rx_len_q   <= rx_data[5:0];
                  rx_state_q <= R_SEQ;
               end
            end
            R_SEQ: begin
               rx_seq_q   <= rx_data;
               rx_rem_q   <= rx_len_q - 6'(MIN_LEN);
               rx_state_q <= (rx_len_q == 6'(MIN_LEN)) ? R_CRC1 : R_DATA;
            end
            R_DATA: begin
               if (rsp_full_tmp) begin
                  tmp_wptr_q <= rsp_wptr_q;
                  rx_state_q <= R_ERROR;
               end else begin
                  tmp_wptr_q <= tmp_wptr_q + RONE;
                  rx_rem_q   <= rx_rem_q - 6'd1;
                  if (rx_rem_q == 6'd1) rx_state_q <= R_CRC1;
               end
            end
            R_CRC1: begin
               rx_c1_q    <= rx_data;
               rx_state_q <= R_CRC2;
            end
            R_CRC2: begin
               rx_c2_q    <= rx_data;
               rx_state_q <= R_EOF;
            end
            R_EOF: begin
               if (rx_commit) begin
                  rsp_wptr_q <= tmp_wptr_q;
                  rx_state_q <= R_SOF;
               end else begin
                  tmp_wptr_q <= rsp_wptr_q;
                  rx_state_q <= R_ERROR;
               end
            end
            default: rx_state_q <= R_ERROR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && rsp_we) rsp_mem[tmp_wptr_q] <= rx_data;
   end

   always_comb begin
      rsp_rptr_d  = rsp_rptr_q + ((rsp_rd_en && rsp_ready_q) ? RONE : '0);
      rsp_ready_d = (rsp_wptr_q != rsp_rptr_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_rptr_q  <= '0;
         rsp_ready_q <= 1'b0;
      end else begin
         rsp_rptr_q  <= rsp_rptr_d;
         rsp_ready_q <= rsp_ready_d;
      end
   end

   assign rsp_ready = rsp_ready_q;
   assign rsp_data  = rsp_mem[rsp_rptr_q];

   // ---------------- sticky error ----------------
   logic error_q;
   always_ff @(posedge clk) begin
      if (!rst_n)                      error_q <= 1'b0;
      else if (clr)                    error_q <= 1'b0;
      else if (rx_to_err || tx_fatal)  error_q <= 1'b1;
   end
   assign error = error_q;
endmodule

// File: tb/tb_frame_host.sv
// Directed bench for frame_host: UART byte model on tx, hand-built response frames on rx.
module tb_frame_host;
  localparam int RB = 8;
  localparam int LB = 2;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_wr_en = 1'b0;
  logic       cmd_full;
  logic [5:0] cmd_len = 6'd0;
  logic       cmd_len_wr_en = 1'b0;
  logic       cmd_len_full;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       rsp_rd_en = 1'b0;
  logic [3:0] ack_seq;
  logic       error;
  logic       clr = 1'b0;

  always #5 clk = ~clk;

  frame_host #(.RING_BITS(RB), .LEN_FIFO_BITS(LB), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_data(cmd_data), .cmd_wr_en(cmd_wr_en), .cmd_full(cmd_full),
    .cmd_len(cmd_len), .cmd_len_wr_en(cmd_len_wr_en), .cmd_len_full(cmd_len_full),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .rsp_rd_en(rsp_rd_en),
    .ack_seq(ack_seq), .error(error), .clr(clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmit model: captures each strobed byte and stays busy for a few cycles
  logic [7:0] cap_q[$];
  int tx_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (tx_en) begin
      cap_q.push_back(tx_data);
      tx_cnt++;
      busy_cnt = 4;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  end

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = {1'b0, r[15:1]} ^ 16'h8408;
      else             r = {1'b0, r[15:1]};
    end
    return r;
  endfunction

  logic [7:0] tx_pl[64];
  logic [7:0] rx_pl[64];

  task automatic wr_payload(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cmd_data = tx_pl[i]; cmd_wr_en = 1'b1;
    end
    @(negedge clk); cmd_wr_en = 1'b0;
  endtask

  task automatic wr_pattern(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cmd_data = 8'(first + i); cmd_wr_en = 1'b1;
    end
    @(negedge clk); cmd_wr_en = 1'b0;
  endtask

  task automatic push_len(input logic [5:0] l);
    @(negedge clk); cmd_len = l; cmd_len_wr_en = 1'b1;
    @(negedge clk); cmd_len_wr_en = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(negedge clk); k++;
    end
    chk({tag, "_arrived"}, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic chk_next(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = (cap_q.size() > 0) ? cap_q.pop_front() : 8'hxx;
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] seq, input int n);
    logic [15:0] c;
    logic [7:0]  len;
    len = 8'(n + 5);
    c = crc_upd(16'hFFFF, len);
    c = crc_upd(c, seq);
    chk_next({tag, "_len"}, len);
    chk_next({tag, "_seq"}, seq);
    for (int i = 0; i < n; i++) begin
      c = crc_upd(c, tx_pl[i]);
      chk_next($sformatf("%s_d%0d", tag, i), tx_pl[i]);
    end
    chk_next({tag, "_crc1"}, c[15:8]);
    chk_next({tag, "_crc2"}, c[7:0]);
    chk_next({tag, "_eof"}, 8'h7E);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] seq, input int n, input bit bad_crc);
    logic [15:0] c;
    logic [7:0]  len;
    len = 8'(n + 5);
    c = crc_upd(16'hFFFF, len);
    rx_byte(len);
    c = crc_upd(c, seq);
    rx_byte(seq);
    for (int i = 0; i < n; i++) begin
      c = crc_upd(c, rx_pl[i]);
      rx_byte(rx_pl[i]);
    end
    if (bad_crc) c = c ^ 16'h0001;
    rx_byte(c[15:8]);
    rx_byte(c[7:0]);
    rx_byte(8'h7E);
  endtask

  task automatic rd_rsp(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_ready"}, 32'(rsp_ready), 32'd1);
    chk(tag, 32'(rsp_data), 32'(exp));
    rsp_rd_en = 1'b1;
    @(negedge clk); rsp_rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tx_en"},        32'(tx_en), 32'd0);
    chk({tag, "_tx_data"},      32'(tx_data), 32'd0);
    chk({tag, "_error"},        32'(error), 32'd0);
    chk({tag, "_ack_seq"},      32'(ack_seq), 32'd0);
    chk({tag, "_cmd_full"},     32'(cmd_full), 32'd0);
    chk({tag, "_cmd_len_full"}, 32'(cmd_len_full), 32'd0);
    chk({tag, "_rsp_ready"},    32'(rsp_ready), 32'd0);
  endtask

  initial begin
    int n0;
    int k;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outs("post_rst");

    // first command frame, payload 01 02
    tx_pl[0] = 8'h01; tx_pl[1] = 8'h02;
    wr_payload(2);
    push_len(6'd2);
    wait_tx("f1", 7, 600);
    expect_frame("f1", 8'h10, 2);

    // bare ack frame 05 11 crc crc 7e
    rx_frame(8'h11, 0, 1'b0);
    chk("ack1_seq", 32'(ack_seq), 32'd1);
    chk("ack1_rsp_ready", 32'(rsp_ready), 32'd0);
    chk("ack1_error", 32'(error), 32'd0);

    // second frame goes out with the next sequence number
    tx_pl[0] = 8'hAA;
    wr_payload(1);
    push_len(6'd1);
    wait_tx("f2", 6, 600);
    expect_frame("f2", 8'h11, 1);
    rx_frame(8'h12, 0, 1'b0);
    chk("ack2_seq", 32'(ack_seq), 32'd2);

    // response with 3-byte payload, not an ack (sender idle)
    rx_pl[0] = 8'hC1; rx_pl[1] = 8'hC2; rx_pl[2] = 8'hC3;
    rx_frame(8'h13, 3, 1'b0);
    rd_rsp("rsp0", 8'hC1);
    rd_rsp("rsp1", 8'hC2);
    rd_rsp("rsp2", 8'hC3);
    @(negedge clk);
    chk("rsp_drained", 32'(rsp_ready), 32'd0);
    chk("rsp_ack_unchanged", 32'(ack_seq), 32'd2);
    @(negedge clk); rsp_rd_en = 1'b1;
    @(negedge clk); rsp_rd_en = 1'b0;
    chk("rd_empty_ignored", 32'(rsp_ready), 32'd0);

    // bad crc: error, nothing delivered
    rx_pl[0] = 8'hD0; rx_pl[1] = 8'hD1;
    rx_frame(8'h14, 2, 1'b1);
    chk("badcrc_error", 32'(error), 32'd1);
    chk("badcrc_rsp_ready", 32'(rsp_ready), 32'd0);
    pulse_clr();
    chk("clr1_error", 32'(error), 32'd0);
    rx_byte(8'h40);
    chk("len40_error", 32'(error), 32'd1);
    pulse_clr();
    rx_byte(8'h04);
    chk("len04_error", 32'(error), 32'd1);
    pulse_clr();
    chk("clr3_error", 32'(error), 32'd0);

    // leading sync bytes ignored, then a valid frame commits at the rolled-back pointer
    rx_byte(8'h7E);
    rx_pl[0] = 8'hE0; rx_pl[1] = 8'hE1;
    rx_frame(8'h15, 2, 1'b0);
    chk("good_error", 32'(error), 32'd0);
    rd_rsp("good0", 8'hE0);
    rd_rsp("good1", 8'hE1);
    @(negedge clk);
    chk("good_drained", 32'(rsp_ready), 32'd0);

    // unacked frame: timeout behaviour
    tx_pl[0] = 8'h55;
    wr_payload(1);
    push_len(6'd1);
    wait_tx("f3", 6, 600);
    expect_frame("f3", 8'h12, 1);
`ifdef FRAME_HOST_RETRANSMIT_EN
    for (int r = 1; r <= 3; r++) begin
      wait_tx($sformatf("retx%0d", r), 6, TO + 600);
      chk($sformatf("retx%0d_error", r), 32'(error), 32'd0);
      expect_frame($sformatf("retx%0d", r), 8'h12, 1);
    end
    k = 0;
    while (error !== 1'b1 && k < TO + 200) begin
      @(negedge clk); k++;
    end
    chk("retx_final_error", 32'(error), 32'd1);
    repeat (TO) @(negedge clk);
    chk("retx_no_more", 32'(cap_q.size()), 32'd0);
`else
    repeat (TO - 60) @(negedge clk);
    chk("to_early_error", 32'(error), 32'd0);
    repeat (120) @(negedge clk);
    chk("to_error", 32'(error), 32'd1);
    repeat (TO) @(negedge clk);
    chk("to_no_retx", 32'(cap_q.size()), 32'd0);
`endif
    pulse_clr();
    chk("to_clr_error", 32'(error), 32'd0);

    // fill the ring: one slot stays empty
    wr_pattern(0, 254);
    chk("fill254_full", 32'(cmd_full), 32'd0);
    wr_pattern(254, 1);
    chk("fill255_full", 32'(cmd_full), 32'd1);
    wr_pattern(255, 1);
    chk("overflow_dropped", 32'(cmd_full), 32'd1);

    // long frame, reset while in DATA
    push_len(6'd58);
    wait_tx("f4", 5, 600);
    chk_next("f4_len", 8'h3F);
    chk_next("f4_seq", 8'h12);
    chk_next("f4_d0", 8'h00);
    chk_next("f4_d1", 8'h01);
    chk_next("f4_d2", 8'h02);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrst");
    n0 = tx_cnt;
    @(negedge clk); rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("midrst_no_tx", 32'(tx_cnt), 32'(n0));
    chk("midrst_idle_error", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
